// File: rtl/pipeline_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard / stall logic.
//   muldiv_state_t : HI/LO unit busy-tracker states
//   MULDIV_CNT_W   : width of the mul/div busy countdown
//   reg_match()    : register-dependency compare used by the hazard unit
package PipelineHazardCtrl;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned MULDIV_CNT_W = 6;
    localparam int unsigned STALL_CNT_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

    // True when source r is produced by a writer with destination dst that is
    // enabled; r0 is hard-wired zero and never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_ADDR_W-1:0] r,
        input logic [REG_ADDR_W-1:0] dst,
        input logic                  en
    );
        return (r != '0) && (r == dst) && en;
    endfunction

endpackage

// File: rtl/pipeline_stall_unit_tracker.sv
// muldiv_busy_tracker: tracks how long the multi-cycle HI/LO unit stays busy
// after an issue in execute.
//   clk, rst_n         : clock, asynchronous active-low reset
//   muldiv_start_exe   : mul/div issuing this cycle (ignored while busy)
//   muldiv_is_div_exe  : issuing op is a divide
//   muldiv_busy        : unit busy; high for exactly N cycles after the issue edge
module muldiv_busy_tracker
    import PipelineHazardCtrl::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic muldiv_start_exe,
    input  logic muldiv_is_div_exe,
    output logic muldiv_busy
);

    localparam logic [MULDIV_CNT_W-1:0] MUL_LOAD = MULDIV_CNT_W'(MUL_CYCLES - 1);
    localparam logic [MULDIV_CNT_W-1:0] DIV_LOAD = MULDIV_CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t           state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load N-1 on issue so BUSY lasts N cycles including count 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (muldiv_start_exe) begin
                    state_d = BUSY;
                    cnt_d   = muldiv_is_div_exe ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - MULDIV_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign muldiv_busy = (state_q == BUSY);

endmodule

// File: rtl/pipeline_stall_unit.sv
// pipeline_stall_unit: decode-stage hazard detection for a 5-stage pipeline.
// Raises a combined stall/flush for load-use, branch-in-decode and HI/LO
// dependencies, and tracks the multi-cycle mul/div unit.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   rs_dec, rt_dec, rs/rt_used_dec    : decode sources and their use flags
//   branch_dec, hilo_read_dec,
//   muldiv_dec                        : decode instruction class
//   wreg_dst_exe, reg_we_exe,
//   mem_to_reg_exe                    : execute-stage writer
//   wreg_dst_dm, mem_to_reg_dm        : memory-stage load
//   muldiv_start_exe, muldiv_is_div_exe : mul/div issue in execute
//   stall_fetch, stall_dec, flush_exe : combinational stall / bubble
//   muldiv_busy                       : HI/LO unit busy
//   stall_count                       : stalled-cycle counter (only with STALL_COUNTER_EN)
// Optional feature macro: STALL_COUNTER_EN
module pipeline_stall_unit
    import PipelineHazardCtrl::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_dec,
    input  logic [REG_ADDR_W-1:0] rt_dec,
    input  logic                  rs_used_dec,
    input  logic                  rt_used_dec,
    input  logic                  branch_dec,
    input  logic                  hilo_read_dec,
    input  logic                  muldiv_dec,
    input  logic [REG_ADDR_W-1:0] wreg_dst_exe,
    input  logic                  reg_we_exe,
    input  logic                  mem_to_reg_exe,
    input  logic [REG_ADDR_W-1:0] wreg_dst_dm,
    input  logic                  mem_to_reg_dm,
    input  logic                  muldiv_start_exe,
    input  logic                  muldiv_is_div_exe,
    output logic                  stall_fetch,
    output logic                  stall_dec,
    output logic                  flush_exe,
    output logic                  muldiv_busy
`ifdef STALL_COUNTER_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    logic rs_exe, rt_exe, rs_dm, rt_dm;
    logic load_use, branch_haz, hilo_haz, stall_any;

    // Per-source dependency matches against execute and memory stages.
    assign rs_exe = rs_used_dec && reg_match(rs_dec, wreg_dst_exe, reg_we_exe);
    assign rt_exe = rt_used_dec && reg_match(rt_dec, wreg_dst_exe, reg_we_exe);
    assign rs_dm  = rs_used_dec && reg_match(rs_dec, wreg_dst_dm, mem_to_reg_dm);
    assign rt_dm  = rt_used_dec && reg_match(rt_dec, wreg_dst_dm, mem_to_reg_dm);

    assign load_use   = mem_to_reg_exe && (rs_exe || rt_exe);
    // Branches compare in decode, so any in-flight producer must drain first.
    assign branch_haz = branch_dec && (rs_exe || rt_exe || rs_dm || rt_dm);
    // HI/LO consumers and new mul/div wait on a busy or just-issuing unit.
    assign hilo_haz   = (hilo_read_dec || muldiv_dec) && (muldiv_busy || muldiv_start_exe);

    assign stall_any   = load_use || branch_haz || hilo_haz;
    assign stall_fetch = stall_any;
    assign stall_dec   = stall_any;
    assign flush_exe   = stall_any;

    muldiv_busy_tracker #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_busy_tracker (
        .clk               (clk),
        .rst_n             (rst_n),
        .muldiv_start_exe  (muldiv_start_exe),
        .muldiv_is_div_exe (muldiv_is_div_exe),
        .muldiv_busy       (muldiv_busy)
    );

`ifdef STALL_COUNTER_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Free-running count of stalled decode cycles; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_dec) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Self-checking bench for pipeline_stall_unit: directed scenarios plus
// randomized traffic against a behavioural model of the hazard rules and a
// remaining-busy-cycles model of the HI/LO unit.
module tb_pipeline_stall_unit;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_dec, rt_dec, wreg_dst_exe, wreg_dst_dm;
    logic       rs_used_dec, rt_used_dec, branch_dec, hilo_read_dec, muldiv_dec;
    logic       reg_we_exe, mem_to_reg_exe, mem_to_reg_dm;
    logic       muldiv_start_exe, muldiv_is_div_exe;
    logic       stall_fetch, stall_dec, flush_exe, muldiv_busy;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int rem   = 0;   // model: busy cycles still to come

    pipeline_stall_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rs_dec            (rs_dec),
        .rt_dec            (rt_dec),
        .rs_used_dec       (rs_used_dec),
        .rt_used_dec       (rt_used_dec),
        .branch_dec        (branch_dec),
        .hilo_read_dec     (hilo_read_dec),
        .muldiv_dec        (muldiv_dec),
        .wreg_dst_exe      (wreg_dst_exe),
        .reg_we_exe        (reg_we_exe),
        .mem_to_reg_exe    (mem_to_reg_exe),
        .wreg_dst_dm       (wreg_dst_dm),
        .mem_to_reg_dm     (mem_to_reg_dm),
        .muldiv_start_exe  (muldiv_start_exe),
        .muldiv_is_div_exe (muldiv_is_div_exe),
        .stall_fetch       (stall_fetch),
        .stall_dec         (stall_dec),
        .flush_exe         (flush_exe),
        .muldiv_busy       (muldiv_busy)
`ifdef STALL_COUNTER_EN
        ,
        .stall_count       (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected stall from the hazard rules, using the model's busy view.
    function automatic bit model_stall();
        bit ld, br, hl;
        bit rs_e, rt_e, rs_m, rt_m;
        rs_e = rs_used_dec && rs_dec != 0 && rs_dec == wreg_dst_exe && reg_we_exe;
        rt_e = rt_used_dec && rt_dec != 0 && rt_dec == wreg_dst_exe && reg_we_exe;
        rs_m = rs_used_dec && rs_dec != 0 && rs_dec == wreg_dst_dm && mem_to_reg_dm;
        rt_m = rt_used_dec && rt_dec != 0 && rt_dec == wreg_dst_dm && mem_to_reg_dm;
        ld = mem_to_reg_exe && (rs_e || rt_e);
        br = branch_dec && (rs_e || rt_e || rs_m || rt_m);
        hl = (hilo_read_dec || muldiv_dec) && ((rem > 0) || muldiv_start_exe);
        return ld || br || hl;
    endfunction

    task automatic clear_inputs();
        rs_dec = 0; rt_dec = 0; rs_used_dec = 0; rt_used_dec = 0;
        branch_dec = 0; hilo_read_dec = 0; muldiv_dec = 0;
        wreg_dst_exe = 0; reg_we_exe = 0; mem_to_reg_exe = 0;
        wreg_dst_dm = 0; mem_to_reg_dm = 0;
        muldiv_start_exe = 0; muldiv_is_div_exe = 0;
    endtask

    // Advance one clock: update the model with the inputs seen at the edge.
    task automatic tick();
        if (!rst_n)                rem = 0;
        else if (rem > 0)          rem = rem - 1;
        else if (muldiv_start_exe) rem = muldiv_is_div_exe ? DIV_N : MUL_N;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b stall=%b expected 0/0", muldiv_busy, stall_dec);
        end
        // Combinational stall still follows hazards during reset.
        wreg_dst_exe = 8; reg_we_exe = 1; mem_to_reg_exe = 1;
        rs_dec = 8; rs_used_dec = 1;
        #1;
        n_cmp++;
        if ({stall_fetch, stall_dec, flush_exe} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_comb_stall: got %b expected 111", {stall_fetch, stall_dec, flush_exe});
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (muldiv_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_busy: got %b expected 0", muldiv_busy);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        wreg_dst_exe = 8; reg_we_exe = 1; mem_to_reg_exe = 1;
        rs_dec = 8; rs_used_dec = 1; rt_dec = 3; rt_used_dec = 1;
        #1;
        n_cmp++;
        if ({stall_fetch, stall_dec, flush_exe} !== 3'b111) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b expected 111", {stall_fetch, stall_dec, flush_exe});
        end
        tick();
        // lw now in memory stage, bubble in execute, add still in decode.
        wreg_dst_exe = 0; reg_we_exe = 0; mem_to_reg_exe = 0;
        wreg_dst_dm = 8; mem_to_reg_dm = 1;
        #1;
        n_cmp++;
        if ({stall_fetch, stall_dec, flush_exe} !== 3'b000) begin
            n_bad++;
            $display("FAIL load_use_release: got %b expected 000", {stall_fetch, stall_dec, flush_exe});
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branch_dec = 1; rs_dec = 4; rs_used_dec = 1; rt_dec = 9; rt_used_dec = 1;
        wreg_dst_exe = 9; reg_we_exe = 1;
        #1;
        n_cmp++;
        if (stall_dec !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_exe: got %b expected 1", stall_dec);
        end
        reg_we_exe = 0; wreg_dst_dm = 9; mem_to_reg_dm = 1;
        #1;
        n_cmp++;
        if (stall_dec !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_dm: got %b expected 1", stall_dec);
        end
        mem_to_reg_dm = 0; rt_dec = 0; wreg_dst_exe = 0; reg_we_exe = 1;
        #1;
        n_cmp++;
        if (stall_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_r0: got %b expected 0", stall_dec);
        end
        // Non-branch reader of an ALU result is forwarded, no stall.
        branch_dec = 0; rt_dec = 9; wreg_dst_exe = 9;
        #1;
        n_cmp++;
        if (stall_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_forward: got %b expected 0", stall_dec);
        end
        tick();
    endtask

    // Issue a mul/div, then hold a HI/LO consumer in decode and count stalls.
    task automatic test_muldiv(input bit is_div, input bit use_mfhi);
        int n, stalls, busy_cyc;
        n = is_div ? DIV_N : MUL_N;
        clear_inputs();
        muldiv_start_exe = 1; muldiv_is_div_exe = is_div;
        hilo_read_dec = use_mfhi; muldiv_dec = !use_mfhi;
        stalls = 0; busy_cyc = 0;
        #1;
        if (stall_dec === 1'b1) stalls++;
        tick();
        muldiv_start_exe = 0; muldiv_is_div_exe = 0;
        for (int c = 1; c <= n; c++) begin
            #1;
            if (muldiv_busy === 1'b1) busy_cyc++;
            if (stall_dec === 1'b1) stalls++;
            tick();
        end
        #1;
        n_cmp++;
        if (busy_cyc !== n) begin
            n_bad++;
            $display("FAIL muldiv_busy_len div=%0b: got %0d expected %0d", is_div, busy_cyc, n);
        end
        n_cmp++;
        if (stalls !== n + 1) begin
            n_bad++;
            $display("FAIL muldiv_stall_len div=%0b: got %0d expected %0d", is_div, stalls, n + 1);
        end
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL muldiv_release div=%0b: busy=%b stall=%b expected 0/0", is_div, muldiv_busy, stall_dec);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        muldiv_start_exe = 1; muldiv_is_div_exe = 1;
        tick();
        clear_inputs();
        for (int c = 1; c < 10; c++) tick();
        n_cmp++;
        if (muldiv_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_div_busy: got %b expected 1", muldiv_busy);
        end
        rst_n = 1'b0;
        rem = 0;
        #2;
        n_cmp++;
        if (muldiv_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_busy: got %b expected 0", muldiv_busy);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        hilo_read_dec = 1;
        tick();
        n_cmp++;
        if (muldiv_busy !== 1'b0 || stall_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: busy=%b stall=%b expected 0/0", muldiv_busy, stall_dec);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        bit exp_s, exp_b;
        int bad_here;
        bad_here = 0;
        for (int i = 0; i < 400; i++) begin
            rs_dec = 5'($urandom_range(0, 3));
            rt_dec = 5'($urandom_range(0, 3));
            wreg_dst_exe = 5'($urandom_range(0, 3));
            wreg_dst_dm  = 5'($urandom_range(0, 3));
            rs_used_dec = 1'($urandom);
            rt_used_dec = 1'($urandom);
            branch_dec = ($urandom_range(0, 3) == 0);
            reg_we_exe = 1'($urandom);
            mem_to_reg_exe = 1'($urandom);
            mem_to_reg_dm = 1'($urandom);
            hilo_read_dec = ($urandom_range(0, 3) == 0);
            muldiv_dec = ($urandom_range(0, 5) == 0);
            muldiv_start_exe = ($urandom_range(0, 7) == 0);
            muldiv_is_div_exe = ($urandom_range(0, 3) == 0);
            #1;
            exp_s = model_stall();
            exp_b = (rem > 0);
            n_cmp++;
            if ({stall_fetch, stall_dec, flush_exe, muldiv_busy} !== {exp_s, exp_s, exp_s, exp_b}) begin
                n_bad++;
                bad_here++;
                if (bad_here <= 10)
                    $display("FAIL random[%0d]: got sf/sd/fl/busy=%b expected %b", i,
                             {stall_fetch, stall_dec, flush_exe, muldiv_busy},
                             {exp_s, exp_s, exp_s, exp_b});
            end
            tick();
        end
        clear_inputs();
        while (rem > 0) tick();
        tick();
    endtask

`ifdef STALL_COUNTER_EN
    task automatic test_stall_count();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        rem = 0;
        #1;
        n_cmp++;
        if (stall_count !== 32'd0) begin
            n_bad++;
            $display("FAIL stall_count_reset: got %0d expected 0", stall_count);
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wreg_dst_exe = 8; reg_we_exe = 1; mem_to_reg_exe = 1;
            rs_dec = 8; rs_used_dec = 1;
            tick();
            clear_inputs();
            tick();
        end
        n_cmp++;
        if (stall_count !== 32'd3) begin
            n_bad++;
            $display("FAIL stall_count_three: got %0d expected 3", stall_count);
        end
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        wreg_dst_exe = 8; reg_we_exe = 1; mem_to_reg_exe = 1;
        rs_dec = 8; rs_used_dec = 1;
        tick();
        n_cmp++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL stall_count_max: got %h expected ffffffff", stall_count);
        end
        tick();
        n_cmp++;
        if (stall_count !== 32'd0) begin
            n_bad++;
            $display("FAIL stall_count_wrap: got %h expected 00000000", stall_count);
        end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv(1'b1, 1'b1);   // div then mflo
        test_muldiv(1'b0, 1'b0);   // mult then second mult
        test_reset_mid_div();
        test_random();
`ifdef STALL_COUNTER_EN
        test_stall_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_unit.md
PIPELINE_STALL_UNIT -- requirements
Module: pipeline_stall_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4, mul busy cycles after issue; legal range 2..63.
REQ-002 Parameter DIV_CYCLES, default 32, div busy cycles after issue; legal range 2..63.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs_dec, rt_dec  input  5 each  source registers of the decode-stage instruction.
REQ-006 rs_used_dec, rt_used_dec  input  1 each  decode instruction reads rs / rt.
REQ-007 branch_dec  input  1  decode instruction is a branch resolved in decode.
REQ-008 hilo_read_dec  input  1  decode instruction is mfhi/mflo.
REQ-009 muldiv_dec  input  1  decode instruction is mult/multu/div/divu.
REQ-010 wreg_dst_exe  input  5; reg_we_exe  input  1; mem_to_reg_exe  input  1  execute-stage writer info.
REQ-011 wreg_dst_dm  input  5; mem_to_reg_dm  input  1  memory-stage load info.
REQ-012 muldiv_start_exe  input  1; muldiv_is_div_exe  input  1  mul/div issuing in execute.
REQ-013 stall_fetch, stall_dec  output  1 each  hold PC and IF/ID register.
REQ-014 flush_exe  output  1  insert bubble into ID/EX register.
REQ-015 muldiv_busy  output  1  HI/LO unit busy.

Function
REQ-016 match_exe(r) SHALL be r != 0 && r == wreg_dst_exe && reg_we_exe; match_dm(r) SHALL be r != 0 && r == wreg_dst_dm && mem_to_reg_dm.
REQ-017 Load-use stall SHALL assert when mem_to_reg_exe and (rs_used_dec && match_exe(rs_dec) || rt_used_dec && match_exe(rt_dec)).
REQ-018 Branch stall SHALL assert when branch_dec and any used source satisfies match_exe or match_dm.
REQ-019 HI/LO stall SHALL assert when (hilo_read_dec || muldiv_dec) && (muldiv_busy || muldiv_start_exe).
REQ-020 stall_fetch = stall_dec = flush_exe SHALL equal the OR of REQ-017..019, combinationally, zero-cycle latency.
REQ-021 FSM states IDLE, BUSY; IDLE + muldiv_start_exe -> BUSY, counter loaded with (muldiv_is_div_exe ? DIV_CYCLES : MUL_CYCLES) - 1.
REQ-022 In BUSY counter SHALL decrement each cycle; BUSY with counter 0 -> IDLE next edge.
REQ-023 muldiv_busy SHALL be 1 exactly in BUSY, i.e. N cycles after the issue edge for N = selected cycle count.
REQ-024 muldiv_start_exe while BUSY SHALL be ignored (cannot occur legally due to REQ-019).
REQ-025 Counter SHALL be 6 bits unsigned; no wrap below 0.

Reset
REQ-026 rst_n low SHALL force IDLE, counter 0, muldiv_busy 0 immediately, independent of clk.
REQ-027 During reset stall outputs SHALL follow REQ-017..019 with muldiv_busy = 0; reset mid-BUSY abandons the operation.
REQ-028 First state update SHALL occur on the first rising clk with rst_n high.

Configuration
REQ-029 Macro STALL_COUNTER_EN compiled in: output stall_count [31:0], reset 0, increments each cycle stall_dec = 1, wraps 0xFFFFFFFF -> 0.
REQ-030 Without STALL_COUNTER_EN: no stall_count port, no counter flops; all other behaviour identical.

Structure
REQ-031 FSM state enum muldiv_state_t and MULDIV_CNT_W = 6 SHALL live in shared package PipelineHazardCtrl.
REQ-032 The mul/div busy FSM + counter SHALL be sub-module muldiv_busy_tracker; hazard compare logic stays in the top.

Verification
REQ-033 lw writes r8 in exe, decode add reads rs=r8 -> stall/flush 1 for one cycle, 0 next cycle after lw moves to dm.
REQ-034 add writes r9 in exe, decode beq uses rt=r9 -> stall 1; same with lw r9 in dm -> stall 1; r0 as dst -> stall 0.
REQ-035 div issues (muldiv_start_exe=1, is_div=1) -> muldiv_busy 1 for exactly 32 cycles; mflo in decode stalls through them, releases on cycle 33.
REQ-036 mult issues -> busy 4 cycles; second mult in decode stalls 4 cycles plus issue cycle.
REQ-037 Assert rst_n low mid-div at busy cycle 10 -> muldiv_busy 0 without clock edge; after release, FSM IDLE, no stall.
REQ-038 With STALL_COUNTER_EN: 3 load-use stalls -> stall_count 3; preload near 0xFFFFFFFF via force -> wraps to 0.
